rr_arb2_stage: RTL and testbench
================================

Name: rr_arb2_stage

Overview:
- Two-input round-robin arbiter with valid/ready handshakes and a registered output stage.
- Sits directly upstream of the team's 2:1 multiplexer.
  - Produces the mux select `sel` (1 = source a, 0 = source b, matching `y = sel ? a : b`).
  - Produces the registered winning data word.
- Guarantees fair, starvation-free sharing of one downstream consumer between two producers.

Parameters:
- WIDTH, 8, data word width of a_data, b_data, y_data.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- a_valid  input  1  source a has a word.
- a_data  input  WIDTH  source a word.
- a_ready  output  1  source a word accepted this cycle (combinational).
- b_valid  input  1  source b has a word.
- b_data  input  WIDTH  source b word.
- b_ready  output  1  source b word accepted this cycle (combinational).
- y_valid  output  1  output register holds a word (registered).
- y_data  output  WIDTH  output word (registered).
- y_ready  input  1  downstream accepts y_data this cycle.
- sel  output  1  source of the word in the output register, 1 = a, 0 = b (registered).

Behaviour:
- Reset values (synchronous, active-high): y_valid=0, y_data=0, sel=0, last=0 (internal last-granted flag; 0 = b granted last). a_ready and b_ready are forced to 0 while rst=1.
- Transfer rule: a word moves on a cycle where valid && ready are both 1. Output transfer is y_valid && y_ready.
- load = !y_valid || y_ready (the output register is free, or is being drained this cycle).
- Grant, combinational:
  - Only a_valid: grant a.
  - Only b_valid: grant b.
  - Both valid: grant a if last=0, else grant b.
  - Neither valid: no grant.
- a_ready = load && grant_a; b_ready = load && grant_b. At most one ready is high per cycle.
- On a clock edge with load=1 and a grant:
  - y_data <= winning data; y_valid <= 1; sel <= winner (1 = a); last <= winner.
- On a clock edge with load=1 and no grant: y_valid <= 0. y_data, sel and last hold.
- On a clock edge with load=0: all registers hold. Output is stalled; y_data and sel must stay stable while y_valid && !y_ready.
- Latency: 1 cycle from input acceptance to y_valid.
- Throughput: 1 word/cycle when y_ready is held at 1. Back-to-back transfers are allowed; drain and refill occur in the same cycle.
- Fairness: with both sources continuously valid and y_ready=1, grants alternate a,b,a,b. The first tie after reset goes to a.
- Sources must hold valid and data stable until ready. The block does not check this.
- Reset mid-transfer: a pending output word is discarded. No ready is asserted in the reset cycle.

Optional Feature:
- Macro: RR_ARB2_PKT_LOCK_EN.
- Defined:
  - Adds input ports a_last and b_last (1 bit each) after the corresponding data ports.
  - Adds output port y_last, registered; reset value 0. Captured alongside y_data.
  - Internal FSM with states ARB, LOCK_A, LOCK_B; reset state ARB.
    - ARB: normal round-robin. An a transfer with a_last=0 goes to LOCK_A; a b transfer with b_last=0 goes to LOCK_B.
    - LOCK_A: only a may be granted; b_ready=0 even if b_valid=1. An a transfer with a_last=1 returns to ARB.
    - LOCK_B: symmetric for b.
  - `last` is updated on every granted transfer. After a packet ends, the round-robin tie-break therefore favours the other source.
- Not defined: no last or y_last ports, no FSM. Every word is arbitrated independently as described above.

Test Plan:
- Reset: assert rst for 2 cycles while a_valid=1, b_valid=1 → a_ready=b_ready=0, y_valid=0, sel=0. After release, first tie grants a.
- Single source: a_valid=1, a_data=0x11, b_valid=0, y_ready=1 → a_ready=1 in cycle 0; cycle 1 y_valid=1, y_data=0x11, sel=1.
- Alternation: a_data=0xAA and b_data=0xBB continuously valid, y_ready=1 for 6 cycles → y_data sequence AA,BB,AA,BB,AA,BB; sel sequence 1,0,1,0,1,0.
- Backpressure: y holds 0xAA, y_ready=0 for 3 cycles with both sources valid → a_ready=b_ready=0; y_data=0xAA and sel=1 stable. On y_ready=1, b is accepted (0xBB) in the same cycle.
- Idle drain: y_valid=1, y_ready=1, no input valid → y_valid=0 next cycle; y_data, sel and last unchanged.
- With RR_ARB2_PKT_LOCK_EN: a sends a 3-beat packet (last on beat 3) while b_valid=1 → b_ready=0 for all 3 beats. The next grant is b, and y_last=1 only on beat 3.

Source files
------------

// File: rtl/rr_arb2_stage_if.sv
// rr_arb2_stage_if
//   Bundles the two source handshakes (a, b) and the registered output
//   handshake (y, sel) of the two-input round-robin arbiter stage.
//
//   Modports:
//     master - producer/consumer side: drives a/b valid+data and y_ready,
//              observes the readies, y_valid, y_data and sel.
//     slave  - arbiter side (rr_arb2_stage): the mirror image.
//
//   Optional: with RR_ARB2_PKT_LOCK_EN defined the interface also carries
//   a_last / b_last (end-of-packet markers) and y_last (registered copy).
interface rr_arb2_stage_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
    logic             sel;
`ifdef RR_ARB2_PKT_LOCK_EN
    logic             a_last;
    logic             b_last;
    logic             y_last;
`endif

    modport master (
`ifdef RR_ARB2_PKT_LOCK_EN
        output a_last, b_last,
        input  y_last,
`endif
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, y_valid, y_data, sel
    );

    modport slave (
`ifdef RR_ARB2_PKT_LOCK_EN
        input  a_last, b_last,
        output y_last,
`endif
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, y_valid, y_data, sel
    );
endinterface

// File: rtl/rr_arb2_stage.sv
// rr_arb2_stage
//   Two-input round-robin arbiter with valid/ready handshakes and a single
//   registered output stage. Feeds a 2:1 mux: sel = 1 means the word in the
//   output register came from source a, 0 means source b.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - rr_arb2_stage_if.slave: a_valid/a_data/a_ready,
//            b_valid/b_data/b_ready (readies combinational),
//            y_valid/y_data/sel (registered), y_ready (downstream accept)
//
//   Optional feature macro: RR_ARB2_PKT_LOCK_EN
//     When defined, a multi-beat packet (a_last/b_last = 0 on all but the
//     final beat) locks the arbiter to its source until the final beat has
//     been accepted, and y_last carries the end-of-packet marker.
module rr_arb2_stage #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    rr_arb2_stage_if.slave bus
);

    logic             y_valid_q;
    logic [WIDTH-1:0] y_data_q;
    logic             sel_q;
    logic             last_q;      // 1 = a was granted most recently
    logic             load;
    logic             rr_a;
    logic             rr_b;
    logic             grant_a;
    logic             grant_b;

`ifdef RR_ARB2_PKT_LOCK_EN
    typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;
    state_t state;
    logic   y_last_q;
`endif

    // The register can take a new word when empty or when it is being
    // drained on this same edge, which gives full throughput.
    assign load = !y_valid_q || bus.y_ready;

    // Plain round-robin choice: on a tie the source not granted last wins.
    always_comb begin
        rr_a = bus.a_valid && (!bus.b_valid || !last_q);
        rr_b = bus.b_valid && (!bus.a_valid ||  last_q);
    end

`ifdef RR_ARB2_PKT_LOCK_EN
    // Inside a packet only the owning source may be granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state)
            LOCK_A:  grant_a = bus.a_valid;
            LOCK_B:  grant_b = bus.b_valid;
            default: begin
                grant_a = rr_a;
                grant_b = rr_b;
            end
        endcase
    end
`else
    assign grant_a = rr_a;
    assign grant_b = rr_b;
`endif

    // Readies are suppressed during reset so nothing is consumed on a
    // cycle whose result is about to be discarded.
    assign bus.a_ready = !rst && load && grant_a;
    assign bus.b_ready = !rst && load && grant_b;

    // Output register, round-robin history and (optionally) packet FSM.
    // With load low everything holds, keeping y_data/sel stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b0;
`ifdef RR_ARB2_PKT_LOCK_EN
            y_last_q  <= 1'b0;
            state     <= ARB;
`endif
        end else if (load) begin
            if (grant_a) begin
                y_valid_q <= 1'b1;
                y_data_q  <= bus.a_data;
                sel_q     <= 1'b1;
                last_q    <= 1'b1;
`ifdef RR_ARB2_PKT_LOCK_EN
                y_last_q  <= bus.a_last;
                state     <= bus.a_last ? ARB : LOCK_A;
`endif
            end else if (grant_b) begin
                y_valid_q <= 1'b1;
                y_data_q  <= bus.b_data;
                sel_q     <= 1'b0;
                last_q    <= 1'b0;
`ifdef RR_ARB2_PKT_LOCK_EN
                y_last_q  <= bus.b_last;
                state     <= bus.b_last ? ARB : LOCK_B;
`endif
            end else begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.y_valid = y_valid_q;
    assign bus.y_data  = y_data_q;
    assign bus.sel     = sel_q;
`ifdef RR_ARB2_PKT_LOCK_EN
    assign bus.y_last  = y_last_q;
`endif

endmodule

// File: tb/tb_rr_arb2_stage.sv
// tb_rr_arb2_stage
//   Directed-vector bench for rr_arb2_stage. Each vector states which source
//   should be accepted; accepted words are queued as expected outputs and a
//   separate monitor pops and compares them whenever y_valid && y_ready.
//   Packet-lock vectors are included when RR_ARB2_PKT_LOCK_EN is defined.
module tb_rr_arb2_stage;

    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rr_arb2_stage_if #(.WIDTH(8)) bus ();

    rr_arb2_stage #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the stimulus and monitor processes.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check the
    // combinational readies before the rising edge, and queue any word
    // that this vector says must be accepted.
    task automatic applyStimulus(input logic r,
                                 input logic av, input logic [7:0] ad, input logic al,
                                 input logic bv, input logic [7:0] bd, input logic bl,
                                 input logic yr, input logic ear, input logic ebr);
        @(negedge clk);
        rst         = r;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.y_ready = yr;
`ifdef RR_ARB2_PKT_LOCK_EN
        bus.a_last  = al;
        bus.b_last  = bl;
`endif
        #2;
        checkOutput("a_ready", {31'b0, bus.a_ready}, {31'b0, ear});
        checkOutput("b_ready", {31'b0, bus.b_ready}, {31'b0, ebr});
        if (!r && ear) sb.push_back('{ad, 1'b1, al});
        if (!r && ebr) sb.push_back('{bd, 1'b0, bl});
    endtask

    // Monitor: samples just before the rising edge, once inputs are settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst === 1'b0 && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got y_data %0h expected no word", bus.y_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("y_data", {24'b0, bus.y_data}, {24'b0, e.data});
                    checkOutput("sel", {31'b0, bus.sel}, {31'b0, e.sel});
`ifdef RR_ARB2_PKT_LOCK_EN
                    checkOutput("y_last", {31'b0, bus.y_last}, {31'b0, e.last});
`endif
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_data  = 8'h00;
        bus.b_valid = 1'b0;
        bus.b_data  = 8'h00;
        bus.y_ready = 1'b0;
`ifdef RR_ARB2_PKT_LOCK_EN
        bus.a_last  = 1'b1;
        bus.b_last  = 1'b1;
`endif

        // Reset held for two cycles with both sources requesting.
        applyStimulus(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 0);
        applyStimulus(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 0);
        checkOutput("reset_y_valid", {31'b0, bus.y_valid}, 32'h0);
        checkOutput("reset_y_data", {24'b0, bus.y_data}, 32'h0);
        checkOutput("reset_sel", {31'b0, bus.sel}, 32'h0);

        // Alternation; first tie after reset goes to a.
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, (i % 2 == 0), (i % 2 == 1));

        // Single source a, then a again to load 0xAA for the stall test.
        applyStimulus(0, 1, 8'h11, 1, 0, 8'h00, 1, 1, 1, 0);
        applyStimulus(0, 1, 8'hAA, 1, 0, 8'h00, 1, 1, 1, 0);
        checkOutput("single_y_valid", {31'b0, bus.y_valid}, 32'h1);
        checkOutput("single_y_data", {24'b0, bus.y_data}, 32'h11);
        checkOutput("single_sel", {31'b0, bus.sel}, 32'h1);

        // Backpressure: output frozen, no source accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'hAA, 1, 1, 8'hBB, 1, 0, 0, 0);
            checkOutput("stall_y_valid", {31'b0, bus.y_valid}, 32'h1);
            checkOutput("stall_y_data", {24'b0, bus.y_data}, 32'hAA);
            checkOutput("stall_sel", {31'b0, bus.sel}, 32'h1);
        end
        // Release: drain AA and accept b in the same cycle.
        applyStimulus(0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 1);

        // Idle drain: register empties, contents and history hold.
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);
        applyStimulus(0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 1, 0);
        checkOutput("drain_y_valid", {31'b0, bus.y_valid}, 32'h0);
        checkOutput("drain_y_data", {24'b0, bus.y_data}, 32'hBB);
        checkOutput("drain_sel", {31'b0, bus.sel}, 32'h0);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);

        // Empty register loads even with y_ready low.
        applyStimulus(0, 0, 8'h00, 1, 1, 8'hCC, 1, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);

        // Reset with a pending word: the word is discarded.
        applyStimulus(0, 1, 8'h5A, 1, 1, 8'h5B, 1, 0, 1, 0);
        applyStimulus(1, 1, 8'h5A, 1, 1, 8'h5B, 1, 0, 0, 0);
        sb.delete(sb.size() - 1);
        applyStimulus(1, 1, 8'h5A, 1, 1, 8'h5B, 1, 0, 0, 0);
        checkOutput("rst2_y_valid", {31'b0, bus.y_valid}, 32'h0);
        checkOutput("rst2_y_data", {24'b0, bus.y_data}, 32'h0);
        checkOutput("rst2_sel", {31'b0, bus.sel}, 32'h0);

`ifdef RR_ARB2_PKT_LOCK_EN
        // Three-beat packet from a locks out b; b wins the next tie.
        applyStimulus(0, 1, 8'hA1, 0, 1, 8'hB1, 1, 1, 1, 0);
        applyStimulus(0, 1, 8'hA2, 0, 1, 8'hB1, 1, 1, 1, 0);
        applyStimulus(0, 1, 8'hA3, 1, 1, 8'hB1, 1, 1, 1, 0);
        applyStimulus(0, 1, 8'hA4, 1, 1, 8'hB1, 1, 1, 0, 1);
`else
        // Tie history restarts from reset: a first, then b.
        applyStimulus(0, 1, 8'hA1, 1, 1, 8'hB1, 1, 1, 1, 0);
        applyStimulus(0, 1, 8'hA2, 1, 1, 8'hB1, 1, 1, 0, 1);
`endif
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);
        @(negedge clk);
        #4;
        checkOutput("scoreboard_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
